// File: rtl/seg_pkg.sv
// seg_pkg: glyph constants, command codes and digit-entry type for seg_scan_disp.
package seg_pkg;
    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_A = 8'h88;
    localparam logic [7:0] SEG_B = 8'h83;
    localparam logic [7:0] SEG_C = 8'hC6;
    localparam logic [7:0] SEG_D = 8'hA1;
    localparam logic [7:0] SEG_E = 8'h86;
    localparam logic [7:0] SEG_F = 8'h8E;
    localparam logic [7:0] SEG_DASH = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] CMD_CLEAR = 8'h80;
    localparam int DIG_W = 5;
    typedef struct packed {
        logic       dash;
        logic [3:0] nib;
    } dig_t;
    localparam logic [7:0] SEG_TAB [16] = '{
        SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
        SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F
    };
endpackage

// File: rtl/seg_scan_disp_if.sv
// seg_scan_disp_if: received-byte strobe in, active-low segments and digit selects out.
interface seg_scan_disp_if #(
    parameter int NUM_DIG = 6
);
    logic [7:0]         rdata;
    logic               rx_sig;
    logic [7:0]         led_data;
    logic [NUM_DIG-1:0] led_sel;
    modport master (output rdata, rx_sig, input led_data, led_sel);
    modport slave (input rdata, rx_sig, output led_data, led_sel);
endinterface

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: {dash, nibble} digit entry to active-low 7-segment glyph, dp off.
module seg_hex_decode
    import seg_pkg::*;
(
    input  dig_t       i_dig,
    output logic [7:0] o_seg
);
    assign o_seg = i_dig.dash ? SEG_DASH : SEG_TAB[i_dig.nib];
endmodule

// File: rtl/seg_scan_disp.sv
// seg_scan_disp: multiplexed NUM_DIG-digit 7-segment driver fed by received bytes, with guard blanking.
// Define SEG_LZB_EN to blank leading zero digits.
module seg_scan_disp
    import seg_pkg::*;
#(
    parameter int NUM_DIG  = 6,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 16
) (
    input logic            sys_clk,
    input logic            rst,
    seg_scan_disp_if.slave bus
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIG);

    dig_t [NUM_DIG-1:0] r_dig;
    logic [CW-1:0]      r_cnt;
    logic [IW-1:0]      r_idx;
    logic [7:0]         r_data;
    logic [NUM_DIG-1:0] r_sel;
    logic               w_wrap;
    logic               w_guard;
    logic               w_blank;
    logic [IW-1:0]      w_pos;
    logic [7:0]         w_glyph;
    dig_t               w_new;

    assign w_wrap  = r_cnt == CW'(SCAN_DIV - 1);
    assign w_guard = r_cnt < CW'(GUARD);
    assign w_pos   = IW'(NUM_DIG - 1) - r_idx;
    assign w_new   = bus.rdata[7:4] == 4'h0 ? dig_t'({1'b0, bus.rdata[3:0]}) : dig_t'({1'b1, 4'h0});

    seg_hex_decode u_dec (
        .i_dig(r_dig[r_idx]),
        .o_seg(w_glyph)
    );

`ifdef SEG_LZB_EN
    logic [NUM_DIG-1:0] w_lz;
    // w_lz[i]: digit i and every digit above it hold a plain zero
    always_comb begin
        w_lz = '0;
        for (int i = 0; i < NUM_DIG; i++) w_lz[i] = (r_dig >> (i * DIG_W)) == '0;
    end
    assign w_blank = r_idx != '0 && w_lz[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_dig  <= '0;
            r_cnt  <= '0;
            r_idx  <= '0;
            r_data <= SEG_BLANK;
            r_sel  <= '1;
        end else begin
            if (bus.rx_sig) r_dig <= bus.rdata == CMD_CLEAR ? '0 : {r_dig[NUM_DIG-2:0], w_new};
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
            if (w_wrap) r_idx <= r_idx == IW'(NUM_DIG - 1) ? '0 : r_idx + 1'b1;
            r_sel  <= w_guard ? '1 : ~(NUM_DIG'(1) << w_pos);
            r_data <= w_guard || w_blank ? SEG_BLANK : w_glyph;
        end
    end

    assign bus.led_data = r_data;
    assign bus.led_sel  = r_sel;
endmodule
